// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// stretching EXEC for divides and MEM for memory ops, and taking interrupts only at commit.
module unidade_controle_multiciclo #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned DIV_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       isFalse,
   input  logic       isInput,
   input  logic       intr,
   output logic       irWrite,
   output logic       pcWrite,
   output logic       regWrite,
   output logic       memWrite,
   output logic       diskWrite,
   output logic       inta,
   output logic       isInsert,
   output logic       isHalt,
   output logic [1:0] pcSource,
   output logic [4:0] aluOp,
   output logic [2:0] state
);

   localparam int unsigned MAX_LAT = (MEM_LAT > DIV_LAT) ? MEM_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_SUBI  = 6'b000010;
   localparam logic [5:0] OP_DIVI  = 6'b000011;
   localparam logic [5:0] OP_MODI  = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_LDK   = 6'b001001;
   localparam logic [5:0] OP_SW    = 6'b001010;
   localparam logic [5:0] OP_SDK   = 6'b001011;
   localparam logic [5:0] OP_J     = 6'b010000;
   localparam logic [5:0] OP_JAL   = 6'b010001;
   localparam logic [5:0] OP_JTM   = 6'b010010;
   localparam logic [5:0] OP_IN    = 6'b010011;
   localparam logic [5:0] OP_JF    = 6'b010100;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] F_ADD = 6'b000000;
   localparam logic [5:0] F_SUB = 6'b000001;
   localparam logic [5:0] F_DIV = 6'b000011;
   localparam logic [5:0] F_MOD = 6'b000100;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_DIV = 5'b00011;
   localparam logic [4:0] ALU_MOD = 5'b00100;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_WAIT_IN = 3'd5,
      S_INTR    = 3'd6,
      S_HALT    = 3'd7
   } state_t;

   state_t           cur;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       op_q;
   logic [5:0]       func_q;

   logic [4:0] alu_sel;
   logic       long_op, mem_op, load_op, st_mem, st_disk, wb_op;
   logic [1:0] jmp_src;
   logic       last_exec, last_mem, commit;

   // Instruction class decode from the latched fields; unknown encodings fall through as NOPs
   always_comb begin
      alu_sel = ALU_ADD;
      long_op = 1'b0;
      mem_op  = 1'b0;
      load_op = 1'b0;
      st_mem  = 1'b0;
      st_disk = 1'b0;
      wb_op   = 1'b0;
      jmp_src = 2'b00;
      case (op_q)
         OP_RTYPE: begin
            case (func_q)
               F_ADD: wb_op = 1'b1;
               F_SUB: begin wb_op = 1'b1; alu_sel = ALU_SUB; end
               F_DIV: begin wb_op = 1'b1; alu_sel = ALU_DIV; long_op = 1'b1; end
               F_MOD: begin wb_op = 1'b1; alu_sel = ALU_MOD; long_op = 1'b1; end
               F_JR:  jmp_src = 2'b10;
               default: ;
            endcase
         end
         OP_ADDI: wb_op = 1'b1;
         OP_SUBI: begin wb_op = 1'b1; alu_sel = ALU_SUB; end
         OP_DIVI: begin wb_op = 1'b1; alu_sel = ALU_DIV; long_op = 1'b1; end
         OP_MODI: begin wb_op = 1'b1; alu_sel = ALU_MOD; long_op = 1'b1; end
         OP_LW, OP_LDK: begin mem_op = 1'b1; load_op = 1'b1; end
         OP_SW:   begin mem_op = 1'b1; st_mem = 1'b1; end
         OP_SDK:  begin mem_op = 1'b1; st_disk = 1'b1; end
         OP_J, OP_JAL, OP_JTM: jmp_src = 2'b01;
         OP_JF:   begin alu_sel = ALU_SUB; jmp_src = isFalse ? 2'b01 : 2'b00; end
         default: ;
      endcase
   end

   assign last_exec = long_op ? (cnt == CNT_W'(DIV_LAT - 1)) : 1'b1;
   assign last_mem  = (cnt == CNT_W'(MEM_LAT - 1));
   // Commit is the final cycle of an instruction, wherever that instruction ends
   assign commit = ((cur == S_EXEC) && last_exec && !mem_op && !wb_op) ||
                   ((cur == S_MEM) && last_mem && !load_op) ||
                   (cur == S_WB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur    <= S_FETCH;
         cnt    <= '0;
         op_q   <= '0;
         func_q <= '0;
      end else begin
         case (cur)
            S_FETCH: begin
               op_q   <= op;
               func_q <= func;
               cur    <= S_DECODE;
            end
            S_DECODE: begin
               cnt <= '0;
               if (op_q == OP_HALT)    cur <= S_HALT;
               else if (op_q == OP_IN) cur <= S_WAIT_IN;
               else                    cur <= S_EXEC;
            end
            S_EXEC: begin
               if (!last_exec) cnt <= cnt + CNT_W'(1);
               else if (mem_op) begin
                  cnt <= '0;
                  cur <= S_MEM;
               end
               else if (wb_op) cur <= S_WB;
               else            cur <= intr ? S_INTR : S_FETCH;
            end
            S_MEM: begin
               if (!last_mem)    cnt <= cnt + CNT_W'(1);
               else if (load_op) cur <= S_WB;
               else              cur <= intr ? S_INTR : S_FETCH;
            end
            S_WB:      cur <= intr ? S_INTR : S_FETCH;
            S_WAIT_IN: if (isInput) cur <= S_WB;
            S_INTR:    cur <= S_FETCH;
            S_HALT:    cur <= S_HALT;
            default:   cur <= S_FETCH;
         endcase
      end
   end

   // Strobes decode from the current state; reset forces every output low at once
   always_comb begin
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      diskWrite = 1'b0;
      inta      = 1'b0;
      isInsert  = 1'b0;
      isHalt    = 1'b0;
      pcSource  = 2'b00;
      aluOp     = 5'b00000;
      state     = 3'(cur);
      if (!rst) begin
         irWrite   = (cur == S_FETCH);
         regWrite  = (cur == S_WB);
         memWrite  = (cur == S_MEM) && last_mem && st_mem;
         diskWrite = (cur == S_MEM) && last_mem && st_disk;
         inta      = (cur == S_INTR);
         isInsert  = (cur == S_WAIT_IN) && !isInput;
         isHalt    = (cur == S_HALT);
         pcWrite   = commit || (cur == S_INTR);
         if (cur == S_INTR)  pcSource = 2'b11;
         else if (commit)    pcSource = jmp_src;
         if (cur == S_EXEC)  aluOp = alu_sel;
      end
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control unit: each instruction's expected per-cycle trace is
// assembled from the instruction class rules and compared against the observed outputs.
module tb_unidade_controle_multiciclo;

   localparam int unsigned MEM_LAT = 2;
   localparam int unsigned DIV_LAT = 4;

   logic       clk, rst, isFalse, isInput, intr;
   logic [5:0] op, func;
   logic       irWrite, pcWrite, regWrite, memWrite, diskWrite, inta, isInsert, isHalt;
   logic [1:0] pcSource;
   logic [4:0] aluOp;
   logic [2:0] state;

   unidade_controle_multiciclo #(.MEM_LAT(MEM_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .isFalse(isFalse), .isInput(isInput),
      .intr(intr), .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
      .memWrite(memWrite), .diskWrite(diskWrite), .inta(inta), .isInsert(isInsert),
      .isHalt(isHalt), .pcSource(pcSource), .aluOp(aluOp), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic ir, pcw, rw, mw, dw, ia, ins, hlt;
      logic [1:0] src;
      logic [4:0] alu;
   } rec_t;

   localparam int K_NOP = 0, K_ALU = 1, K_LOAD = 2, K_SW = 3, K_SDK = 4,
                  K_JMP = 5, K_JF = 6, K_JR = 7, K_IN = 8, K_HALT = 9;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   errors = 0;
   int   checks = 0;
   int   add_commit = 0;

   logic [5:0] op_tab [17] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11,
                               6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd5, 6'd33, 6'd62};
   logic [5:0] fn_tab [7]  = '{6'd0, 6'd1, 6'd3, 6'd4, 6'd8, 6'd2, 6'd63};

   // Instruction set table: class, ALU code and whether EXEC is stretched
   function automatic void classify(input logic [5:0] o, input logic [5:0] f,
                                    output int kind, output logic [4:0] alu, output bit long_op);
      kind = K_NOP; alu = 5'd0; long_op = 1'b0;
      case (o)
         6'd0: case (f)
                  6'd0: kind = K_ALU;
                  6'd1: begin kind = K_ALU; alu = 5'd1; end
                  6'd3: begin kind = K_ALU; alu = 5'd3; long_op = 1'b1; end
                  6'd4: begin kind = K_ALU; alu = 5'd4; long_op = 1'b1; end
                  6'd8: kind = K_JR;
                  default: kind = K_NOP;
               endcase
         6'd1: kind = K_ALU;
         6'd2: begin kind = K_ALU; alu = 5'd1; end
         6'd3: begin kind = K_ALU; alu = 5'd3; long_op = 1'b1; end
         6'd4: begin kind = K_ALU; alu = 5'd4; long_op = 1'b1; end
         6'd8, 6'd9: kind = K_LOAD;
         6'd10: kind = K_SW;
         6'd11: kind = K_SDK;
         6'd16, 6'd17, 6'd18: kind = K_JMP;
         6'd19: kind = K_IN;
         6'd20: begin kind = K_JF; alu = 5'd1; end
         6'd63: kind = K_HALT;
         default: kind = K_NOP;
      endcase
   endfunction

   function automatic rec_t mk(input logic [2:0] st);
      rec_t r = '0;
      r.st = st;
      return r;
   endfunction

   // Expected cycle-by-cycle trace of one instruction, starting at its FETCH cycle
   task automatic build(input logic [5:0] o, input logic [5:0] f, input bit isf,
                        input int intr_from, input int in_wait, input int halt_cycles);
      int kind; logic [4:0] alu; bit long_op; rec_t r; int n;
      exp_q.delete();
      classify(o, f, kind, alu, long_op);
      r = mk(3'd0); r.ir = 1'b1; exp_q.push_back(r);
      exp_q.push_back(mk(3'd1));
      if (kind == K_HALT) begin
         for (int i = 0; i < halt_cycles; i++) begin r = mk(3'd7); r.hlt = 1'b1; exp_q.push_back(r); end
         return;
      end
      if (kind == K_IN) begin
         for (int i = 0; i < in_wait; i++) begin r = mk(3'd5); r.ins = 1'b1; exp_q.push_back(r); end
         exp_q.push_back(mk(3'd5));
         r = mk(3'd4); r.rw = 1'b1; r.pcw = 1'b1; exp_q.push_back(r);
      end else begin
         n = long_op ? DIV_LAT : 1;
         for (int i = 0; i < n; i++) begin
            r = mk(3'd2); r.alu = alu;
            if (i == n - 1 && (kind == K_NOP || kind == K_JMP || kind == K_JF || kind == K_JR)) begin
               r.pcw = 1'b1;
               r.src = (kind == K_JMP) ? 2'd1 : (kind == K_JR) ? 2'd2 : (kind == K_JF && isf) ? 2'd1 : 2'd0;
            end
            exp_q.push_back(r);
         end
         if (kind == K_LOAD || kind == K_SW || kind == K_SDK)
            for (int i = 0; i < MEM_LAT; i++) begin
               r = mk(3'd3);
               if (i == MEM_LAT - 1 && kind != K_LOAD) begin
                  r.mw = (kind == K_SW); r.dw = (kind == K_SDK); r.pcw = 1'b1;
               end
               exp_q.push_back(r);
            end
         if (kind == K_ALU || kind == K_LOAD) begin
            r = mk(3'd4); r.rw = 1'b1; r.pcw = 1'b1; exp_q.push_back(r);
         end
      end
      if (exp_q.size() - 1 >= intr_from) begin
         r = mk(3'd6); r.ia = 1'b1; r.pcw = 1'b1; r.src = 2'd3; exp_q.push_back(r);
      end
   endtask

   function automatic rec_t sample();
      rec_t r;
      r.st = state; r.ir = irWrite; r.pcw = pcWrite; r.rw = regWrite; r.mw = memWrite;
      r.dw = diskWrite; r.ia = inta; r.ins = isInsert; r.hlt = isHalt; r.src = pcSource; r.alu = aluOp;
      return r;
   endfunction

   function automatic void drive_cycle(input int c, input logic [5:0] o, input logic [5:0] f,
                                       input bit isf, input int intr_from, input int in_wait);
      op      = (c == 0) ? o : 6'($urandom);
      func    = (c == 0) ? f : 6'($urandom);
      isFalse = isf;
      intr    = (c >= intr_from);
      isInput = (c >= 2 + in_wait);
   endfunction

   // Drive one instruction for exactly the length of its expected trace, recording outputs
   task automatic play(input logic [5:0] o, input logic [5:0] f, input bit isf,
                       input int intr_from, input int in_wait);
      obs_q.delete();
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge clk);
         drive_cycle(c, o, f, isf, intr_from, in_wait);
         #1 obs_q.push_back(sample());
      end
      intr = 1'b0;
      isInput = 1'b0;
   endtask

   function automatic int commit_idx();
      for (int i = 0; i < obs_q.size(); i++)
         if (obs_q[i].pcw && !obs_q[i].ia) return i;
      return -1;
   endfunction

   task automatic test_reset();
      rec_t r;
      @(negedge clk);
      op = 6'h3f; intr = 1'b1; isInput = 1'b1; isFalse = 1'b1;
      #1 checks++;
      if (sample() !== rec_t'(0)) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", sample(), rec_t'(0));
      end
      @(posedge clk);
      #1 rst = 1'b0; intr = 1'b0; isInput = 1'b0; isFalse = 1'b0;
      #1 r = mk(3'd0); r.ir = 1'b1; checks++;
      if (sample() !== r) begin
         errors++; $display("FAIL reset_release_fetch: got %h expected %h", sample(), r);
      end
   endtask

   task automatic test_add();
      build(6'd0, 6'd0, 1'b0, 99, 0, 0);
      play(6'd0, 6'd0, 1'b0, 99, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL add cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      add_commit = commit_idx();
      checks++;
      if (add_commit != 3) begin
         errors++; $display("FAIL add_commit_cycle: got %0d expected 3", add_commit);
      end
   endtask

   task automatic test_divi();
      int d;
      build(6'd3, 6'd0, 1'b0, 99, 0, 0);
      play(6'd3, 6'd0, 1'b0, 99, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL divi cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      d = commit_idx() - add_commit;
      checks++;
      if (d != 3) begin
         errors++; $display("FAIL divi_delta: got %0d expected 3", d);
      end
   endtask

   task automatic test_sw();
      int mw_at;
      build(6'd10, 6'd0, 1'b0, 99, 0, 0);
      play(6'd10, 6'd0, 1'b0, 99, 0);
      mw_at = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL sw cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         if (obs_q[i].mw) mw_at = i;
      end
      checks++;
      if (mw_at != 4) begin
         errors++; $display("FAIL sw_memwrite_cycle: got %0d expected 4", mw_at);
      end
   endtask

   task automatic test_intr_hold();
      int early;
      build(6'd3, 6'd0, 1'b0, 3, 0, 0);
      play(6'd3, 6'd0, 1'b0, 3, 0);
      early = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL intr_hold cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         if (obs_q[i].ia && i < 7) early++;
      end
      checks++;
      if (early != 0) begin
         errors++; $display("FAIL intr_early_ack: got %0d acks expected 0", early);
      end
   endtask

   task automatic test_in();
      build(6'd19, 6'd0, 1'b0, 99, 5, 0);
      play(6'd19, 6'd0, 1'b0, 99, 5);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL in_wait cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] o, f; bit isf; int ifr, w;
      for (int k = 0; k < 200; k++) begin
         o   = op_tab[$urandom_range(0, 16)];
         f   = fn_tab[$urandom_range(0, 6)];
         isf = 1'($urandom);
         ifr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : 99;
         w   = int'($urandom_range(0, 6));
         build(o, f, isf, ifr, w, 0);
         play(o, f, isf, ifr, w);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL random op=%0d func=%0d isf=%0d intr_from=%0d cycle %0d: got %h expected %h",
                        o, f, isf, ifr, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_rst_mid_mem();
      build(6'd10, 6'd0, 1'b0, 99, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive_cycle(c, 6'd10, 6'd0, 1'b0, 99, 0);
         #1 checks++;
         if (sample() !== exp_q[c]) begin
            errors++; $display("FAIL rst_mem_lead cycle %0d: got %h expected %h", c, sample(), exp_q[c]);
         end
      end
      #1 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 checks++;
         if (sample() !== rec_t'(0)) begin
            errors++; $display("FAIL rst_mid_mem step %0d: got %h expected %h", c, sample(), rec_t'(0));
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_halt();
      build(6'd63, 6'd0, 1'b0, 0, 1, 8);
      play(6'd63, 6'd0, 1'b1, 0, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL halt cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1 checks++;
      if (sample() !== rec_t'(0)) begin
         errors++; $display("FAIL halt_reset: got %h expected %h", sample(), rec_t'(0));
      end
      @(posedge clk);
      #1 rst = 1'b0;
      build(6'd1, 6'd0, 1'b0, 99, 0, 0);
      play(6'd1, 6'd0, 1'b0, 99, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL post_halt_addi cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; func = '0; isFalse = 1'b0; isInput = 1'b0; intr = 1'b0;
      test_reset();
      test_add();
      test_divi();
      test_sw();
      test_intr_hold();
      test_in();
      test_random();
      test_rst_mid_mem();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
